// File: rtl/mips_fetch_unit_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Imported by the fetch unit, its next-PC helper and the bus interface users.
package mips_fetch_unit_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;
  localparam int PC_INC      = 4;
  localparam int CNT_W       = $clog2(INSTR_BYTES);

  // Core-side control that only matters in the handshake cycle
  typedef struct packed {
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] se_imm;
    logic [25:0] jump_value;
  } core_ctrl_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus: byte-wide IMEM read port plus the instruction handshake to the core.
// master = fetch unit, slave = core/IMEM side.
interface mips_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_rdata;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch;
  logic              zero;
  logic              jump;
  logic [31:0]       se_imm;
  logic [25:0]       jump_value;
  logic              redirect;

  modport master (
    output imem_addr, instr, pc, instr_valid, redirect,
    input  imem_rdata, instr_ready, branch, zero, jump, se_imm, jump_value
  );

  modport slave (
    input  imem_addr, instr, pc, instr_valid, redirect,
    output imem_rdata, instr_ready, branch, zero, jump, se_imm, jump_value
  );
endinterface

// File: rtl/mips_fetch_unit_next_pc.sv
// Combinational next-PC select: sequential, taken branch or jump (jump has priority).
// All arithmetic is done 32-bit wide and truncated to ADDR_W.
module mips_next_pc
  import mips_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  core_ctrl_t        ctrl_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              taken_o
);
  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic        unused_bits;

  assign pc4     = 32'(pc_i) + 32'(PC_INC);
  assign br_tgt  = pc4 + {ctrl_i.se_imm[29:0], 2'b00};
  assign jmp_tgt = {pc4[31:28], ctrl_i.jump_value, 2'b00};

  always_comb begin
    next_pc_o = pc4[ADDR_W-1:0];
    taken_o   = 1'b0;
    if (ctrl_i.jump) begin
      next_pc_o = jmp_tgt[ADDR_W-1:0];
      taken_o   = 1'b1;
    end else if (ctrl_i.branch && ctrl_i.zero) begin
      next_pc_o = br_tgt[ADDR_W-1:0];
      taken_o   = 1'b1;
    end
  end

  // Bits above the PC width only matter for wider configurations
  assign unused_bits = ^{ctrl_i.se_imm[31:30], pc4[31:ADDR_W],
                         br_tgt[31:ADDR_W], jmp_tgt[31:ADDR_W]};

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: gathers 4 big-endian IMEM bytes per instruction, offers it to the core
// with valid/ready, and steps the PC from the core's branch/jump outputs at the handshake.
module mips_fetch_unit
  import mips_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_fetch_unit_if.master bus
);
  fetch_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic              redirect_q;
  logic              taken;
  logic              hs;
  core_ctrl_t        ctrl;

  assign ctrl = '{
    branch:     bus.branch,
    zero:       bus.zero,
    jump:       bus.jump,
    se_imm:     bus.se_imm,
    jump_value: bus.jump_value
  };

  mips_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_i      (pc_q),
    .ctrl_i    (ctrl),
    .next_pc_o (pc_d),
    .taken_o   (taken)
  );

  assign hs = valid_q & bus.instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        FETCH: begin
          instr_q <= {instr_q[23:0], bus.imem_rdata};
          if (cnt_q == CNT_W'(INSTR_BYTES - 1)) begin
            cnt_q   <= '0;
            state_q <= VALID;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        VALID: begin
          if (hs) begin
            pc_q       <= pc_d;
            state_q    <= FETCH;
            valid_q    <= 1'b0;
            redirect_q <= taken;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // cnt_q is held at 0 in VALID, so this also parks the address at pc there
  assign bus.imem_addr   = pc_q + ADDR_W'(cnt_q);
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.redirect    = redirect_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: drives on negedge, checks on negedge.
module tb_mips_fetch_unit;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mips_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  assign bus.imem_rdata = mem[bus.imem_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.instr_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " valid"}, 32'(bus.instr_valid), 32'h1);
  endtask

  // Called at a negedge with instr_valid=1; returns at the negedge after the handshake edge
  task automatic handshake(input logic b, input logic z, input logic j,
                           input logic [31:0] imm, input logic [25:0] jv);
    bus.instr_ready = 1'b1;
    bus.branch      = b;
    bus.zero        = z;
    bus.jump        = j;
    bus.se_imm      = imm;
    bus.jump_value  = jv;
    @(negedge clk);
    // Garbage control while no handshake is in progress must be ignored
    bus.instr_ready = 1'b0;
    bus.branch      = 1'b1;
    bus.zero        = 1'b1;
    bus.jump        = 1'b1;
    bus.se_imm      = 32'h0000_0040;
    bus.jump_value  = 26'h0000_03F;
  endtask

  task automatic seq_step(input string tag, input logic [7:0] exp_pc);
    wait_valid(tag);
    handshake(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    chk({tag, " pc"}, 32'(bus.pc), 32'(exp_pc));
    chk({tag, " redirect"}, 32'(bus.redirect), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[8'h00], mem[8'h01], mem[8'h02], mem[8'h03]} = 32'h02CD_F824;
    {mem[8'h04], mem[8'h05], mem[8'h06], mem[8'h07]} = 32'h1122_3344;
    {mem[8'h08], mem[8'h09], mem[8'h0A], mem[8'h0B]} = 32'hAABB_CCDD;
    {mem[8'h0C], mem[8'h0D], mem[8'h0E], mem[8'h0F]} = 32'h0102_0304;
    {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} = 32'h10A6_FFFF;
    {mem[8'h14], mem[8'h15], mem[8'h16], mem[8'h17]} = 32'h5566_7788;
    {mem[8'h18], mem[8'h19], mem[8'h1A], mem[8'h1B]} = 32'h0801_0004;
    {mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]} = 32'hDEAD_BEEF;

    rst_n           = 1'b0;
    bus.instr_ready = 1'b1;
    bus.branch      = 1'b0;
    bus.zero        = 1'b0;
    bus.jump        = 1'b0;
    bus.se_imm      = 32'h0;
    bus.jump_value  = 26'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst pc", 32'(bus.pc), 32'h00);
    chk("rst addr", 32'(bus.imem_addr), 32'h00);
    chk("rst instr", bus.instr, 32'h0);
    chk("rst valid", 32'(bus.instr_valid), 32'h0);
    chk("rst redirect", 32'(bus.redirect), 32'h0);

    // First fetch with ready held high: addresses 00..03, valid 4 clocks later
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fetch0 addr%0d", i), 32'(bus.imem_addr), 32'(i));
      chk($sformatf("fetch0 valid%0d", i), 32'(bus.instr_valid), 32'h0);
      @(negedge clk);
    end
    chk("fetch0 valid", 32'(bus.instr_valid), 32'h1);
    chk("fetch0 instr", bus.instr, 32'h02CD_F824);
    chk("fetch0 pc", 32'(bus.pc), 32'h00);
    @(negedge clk);
    bus.instr_ready = 1'b0;
    chk("hs0 pc", 32'(bus.pc), 32'h04);
    chk("hs0 valid", 32'(bus.instr_valid), 32'h0);

    // Stall for 3 cycles in VALID
    wait_valid("stall");
    for (int i = 0; i < 3; i++) begin
      bus.branch = 1'b1; bus.zero = 1'b1; bus.jump = 1'b1;
      @(negedge clk);
      chk($sformatf("stall instr%0d", i), bus.instr, 32'h1122_3344);
      chk($sformatf("stall pc%0d", i), 32'(bus.pc), 32'h04);
      chk($sformatf("stall addr%0d", i), 32'(bus.imem_addr), 32'h04);
      chk($sformatf("stall valid%0d", i), 32'(bus.instr_valid), 32'h1);
    end
    handshake(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    chk("stall-hs pc", 32'(bus.pc), 32'h08);
    chk("stall-hs valid", 32'(bus.instr_valid), 32'h0);

    seq_step("seq8", 8'h0C);
    seq_step("seqC", 8'h10);

    // Taken branch back to itself
    wait_valid("br1");
    chk("br1 instr", bus.instr, 32'h10A6_FFFF);
    handshake(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 26'h0);
    chk("br1 pc", 32'(bus.pc), 32'h10);
    chk("br1 redirect", 32'(bus.redirect), 32'h1);
    @(negedge clk);
    chk("br1 redirect drop", 32'(bus.redirect), 32'h0);

    // Not-taken branch
    wait_valid("br0");
    handshake(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 26'h0);
    chk("br0 pc", 32'(bus.pc), 32'h14);
    chk("br0 redirect", 32'(bus.redirect), 32'h0);

    seq_step("seq14", 8'h18);

    // Jump
    wait_valid("jmp");
    handshake(1'b0, 1'b0, 1'b1, 32'h0, 26'h010_0004);
    chk("jmp pc", 32'(bus.pc), 32'h10);
    chk("jmp redirect", 32'(bus.redirect), 32'h1);

    seq_step("seq10", 8'h14);
    seq_step("seq14b", 8'h18);

    // Jump wins over a taken branch
    wait_valid("jmpbr");
    handshake(1'b1, 1'b1, 1'b1, 32'h0000_0008, 26'h010_0004);
    chk("jmpbr pc", 32'(bus.pc), 32'h10);
    chk("jmpbr redirect", 32'(bus.redirect), 32'h1);

    // Jump to the top of the address space, then wrap sequentially
    wait_valid("jmpFC");
    handshake(1'b0, 1'b0, 1'b1, 32'h0, 26'h000_003F);
    chk("jmpFC pc", 32'(bus.pc), 32'hFC);
    wait_valid("wrap");
    chk("wrap instr", bus.instr, 32'hDEAD_BEEF);
    handshake(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    chk("wrap pc", 32'(bus.pc), 32'h00);
    chk("wrap addr", 32'(bus.imem_addr), 32'h00);
    chk("wrap redirect", 32'(bus.redirect), 32'h0);

    seq_step("seq0", 8'h04);

    // Reset mid-fetch at cnt=2
    repeat (2) @(negedge clk);
    chk("mid addr", 32'(bus.imem_addr), 32'h06);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(bus.instr_valid), 32'h0);
    chk("mid rst pc", 32'(bus.pc), 32'h00);
    chk("mid rst instr", bus.instr, 32'h0);
    chk("mid rst addr", 32'(bus.imem_addr), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("refetch addr%0d", i), 32'(bus.imem_addr), 32'(i));
      @(negedge clk);
    end
    chk("refetch valid", 32'(bus.instr_valid), 32'h1);
    chk("refetch instr", bus.instr, 32'h02CD_F824);
    chk("refetch pc", 32'(bus.pc), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
